// File: rtl/framebuffer_store_pkg.sv
// Shared definitions for the framebuffer write (store) and read (fetch) paths:
// controller state encoding, frame geometry defaults and idle-timer helpers.
package framebuffer_store_pkg;

  // 64x32 pixels, RGB565, two bytes per pixel
  localparam int FB_FRAME_BYTES = 4096;
  localparam int FB_ADDR_WIDTH  = 12;

  // 1 ms at 53.2 MHz
  localparam logic [15:0] FB_IDLE_TIMEOUT = 16'd53200;

  localparam int TIMER_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_WRITE   = 2'd2
  } fb_state_t;

  // Count value at which the idle timer flags expiry. The timer reads 1 in the
  // first cycle after it is cleared, so it reaches 'limit' in the cycle that
  // lies 'limit' cycles after the clearing event; the value one below that is
  // the one the controller must act on to present its pulse exactly then.
  function automatic logic [TIMER_WIDTH-1:0] timer_terminal(input logic [TIMER_WIDTH-1:0] limit);
    return limit - 16'd1;
  endfunction

endpackage

// File: rtl/framebuffer_store_timer.sv
// Idle counter for the store controller: counts cycles since the last clear
// and raises a terminal-count flag when a partial frame has gone stale.
module framebuffer_store_timer
  import framebuffer_store_pkg::*;
#(
  parameter logic [TIMER_WIDTH-1:0] LIMIT = FB_IDLE_TIMEOUT
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clear,
  output logic terminal
);

  logic [TIMER_WIDTH-1:0] count;

  // Elapsed-cycle counter; the clearing edge is itself the first elapsed cycle
  // and the count saturates once the terminal value is reached
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd1;
    end else if (!terminal) begin
      count <= count + 16'd1;
    end else begin
      count <= count;
    end
  end

  assign terminal = (count == timer_terminal(LIMIT));

endmodule

// File: rtl/framebuffer_store.sv
// Framebuffer store controller: turns a stream of received bytes into
// sequential byte writes on framebuffer port A, one frame at a time, with
// an idle timeout that abandons frames whose byte stream stalls.
module framebuffer_store
  import framebuffer_store_pkg::*;
#(
  parameter int          FRAME_BYTES  = FB_FRAME_BYTES,
  parameter int          ADDR_WIDTH   = FB_ADDR_WIDTH,
  parameter logic [15:0] IDLE_TIMEOUT = FB_IDLE_TIMEOUT
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  frame_start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_data_out,
  output logic                  ram_clk_enable,
  output logic                  ram_write_enable,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);

  fb_state_t             state;
  logic [ADDR_WIDTH-1:0] addr;        // address the next accepted byte goes to
  logic                  last_write;  // the write now on the port ends the frame
  logic                  timer_clear;
  logic                  timeout;

  // The idle timer only runs while a frame is open and no byte or restart arrives
  always_comb begin
    timer_clear = 1'b0;
    if ((state == ST_IDLE) || frame_start || rx_valid) begin
      timer_clear = 1'b1;
    end else begin
      timer_clear = 1'b0;
    end
  end

  framebuffer_store_timer #(
    .LIMIT(IDLE_TIMEOUT)
  ) u_timer (
    .clk_in  (clk_in),
    .reset   (reset),
    .clear   (timer_clear),
    .terminal(timeout)
  );

  // Controller FSM; every port output is a register updated here. A byte
  // accepted in RECEIVE or WRITE is presented on the port in the next cycle,
  // and the address advances as the write is issued.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      addr             <= ADDR_ZERO;
      last_write       <= 1'b0;
      ram_addr         <= ADDR_ZERO;
      ram_data_out     <= 8'd0;
      ram_clk_enable   <= 1'b0;
      ram_write_enable <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      ram_clk_enable   <= 1'b0;
      ram_write_enable <= 1'b0;
      frame_done       <= 1'b0;
      frame_error      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            addr  <= ADDR_ZERO;
            state <= ST_RECEIVE;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        ST_RECEIVE: begin
          if (frame_start) begin
            // restart wins over a coincident byte, which is dropped
            addr  <= ADDR_ZERO;
            state <= ST_RECEIVE;
            busy  <= 1'b1;
          end else if (rx_valid) begin
            ram_clk_enable   <= 1'b1;
            ram_write_enable <= 1'b1;
            ram_addr         <= addr;
            ram_data_out     <= rx_data;
            last_write       <= (addr == LAST_ADDR);
            addr             <= addr + ADDR_ONE;
            state            <= ST_WRITE;
            busy             <= 1'b1;
          end else if (timeout) begin
            frame_error <= 1'b1;
            addr        <= ADDR_ZERO;
            state       <= ST_IDLE;
            busy        <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (frame_start) begin
            // the write already on the port completes; the frame restarts
            addr  <= ADDR_ZERO;
            state <= ST_RECEIVE;
            busy  <= 1'b1;
          end else if (last_write) begin
            frame_done <= 1'b1;
            addr       <= ADDR_ZERO;
            state      <= ST_IDLE;
            busy       <= 1'b0;
          end else if (rx_valid) begin
            // back-to-back byte: issue the following write immediately
            ram_clk_enable   <= 1'b1;
            ram_write_enable <= 1'b1;
            ram_addr         <= addr;
            ram_data_out     <= rx_data;
            last_write       <= (addr == LAST_ADDR);
            addr             <= addr + ADDR_ONE;
            state            <= ST_WRITE;
            busy             <= 1'b1;
          end else begin
            state <= ST_RECEIVE;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          addr  <= ADDR_ZERO;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
